// File: rtl/ram1_master.sv
// ram1 chip-interface initiator: sequences single load/store requests
// from the MEM stage into ce/re/we strobes and returns one response each.
module ram1_master #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              stall_o,
    output logic              ram_ce_o,
    output logic              ram_re_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_data_i
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WS,
        WE,
        WH
    } state_t;

    localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

    state_t            state_q;
    state_t            state_d;
    logic [3:0]        cnt_q;
    logic [3:0]        cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              accept;
    logic              rsp_set;
    logic              rsp_rd;
    logic              wr_phase;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        rsp_set   = 1'b0;
        rsp_rd    = 1'b0;
        ram_ce_o  = 1'b0;
        ram_re_o  = 1'b0;
        ram_we_o  = 1'b0;
        req_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = RD_LOAD;
                    state_d = req_we ? WS : RD;
                end
            end
            RD: begin
                ram_ce_o = 1'b1;
                ram_re_o = 1'b1;
                if (cnt_q == 4'd0) begin
                    rsp_set = 1'b1;
                    rsp_rd  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WS: begin
                ram_ce_o = 1'b1;
                cnt_d    = WR_LOAD;
                state_d  = WE;
            end
            WE: begin
                ram_ce_o = 1'b1;
                ram_we_o = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = WH;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WH: begin
                ram_ce_o = 1'b1;
                rsp_set  = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            data_q    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (accept) begin
                addr_q <= req_addr;
                data_q <= req_wdata;
            end
            rsp_valid <= rsp_set;
            if (rsp_set) begin
                rsp_rdata <= rsp_rd ? ram_data_i : '0;
            end
        end
    end

    // Latched values only reach the bus while busy; idle bus is all zero.
    assign wr_phase   = (state_q == WS) || (state_q == WE) ||
                        (state_q == WH);
    assign ram_addr_o = (state_q != IDLE) ? addr_q : '0;
    assign ram_data_o = wr_phase ? data_q : '0;
    assign stall_o    = (state_q != IDLE);

endmodule
